// File: rtl/demux_lane_dispatcher.sv
// Buffered round-robin sequencer feeding a 2-lane demux: queues words in a FIFO
// and dispatches one per cycle to whichever lane is ready, alternating lanes.
module demux_lane_dispatcher #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N-1:0]             in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               lane_ready,
  output logic [N-1:0]             f,
  output logic                     s,
  output logic [1:0]               w_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     blocked
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  state_e          state_s;
  logic [N-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            next_lane_q, next_lane_d;
  logic [N-1:0]    f_q, f_d;
  logic            s_q, s_d;
  logic [1:0]      w_valid_q, w_valid_d;
  logic            blocked_q, blocked_d;
  logic            push_s;
  logic            pop_s;
  logic            lane_s;

  assign in_ready = (count_q < CW'(DEPTH));
  assign push_s   = in_valid && in_ready;

  // State is a pure function of current occupancy and lane readiness, no history.
  always_comb begin
    state_s = ST_IDLE;
    if (count_q == {CW{1'b0}}) begin
      state_s = ST_IDLE;
    end else if (lane_ready == 2'b00) begin
      state_s = ST_BLOCKED;
    end else begin
      state_s = ST_ACTIVE;
    end
  end

  // Dispatch decision, output next-state and FIFO bookkeeping.
  always_comb begin
    f_d         = f_q;
    s_d         = s_q;
    w_valid_d   = 2'b00;
    blocked_d   = 1'b0;
    next_lane_d = next_lane_q;
    pop_s       = 1'b0;
    lane_s      = next_lane_q;
    case (state_s)
      ST_ACTIVE: begin
        lane_s      = lane_ready[next_lane_q] ? next_lane_q : ~next_lane_q;
        pop_s       = 1'b1;
        f_d         = mem_q[rd_ptr_q];
        s_d         = lane_s;
        w_valid_d   = lane_s ? 2'b10 : 2'b01;
        next_lane_d = ~lane_s;
      end
      ST_BLOCKED: begin
        blocked_d = 1'b1;
      end
      ST_IDLE: begin
        blocked_d = 1'b0;
      end
      default: begin
        blocked_d = 1'b0;
      end
    endcase

    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1'b1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      next_lane_q <= 1'b0;
      f_q         <= {N{1'b0}};
      s_q         <= 1'b0;
      w_valid_q   <= 2'b00;
      blocked_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      next_lane_q <= next_lane_d;
      f_q         <= f_d;
      s_q         <= s_d;
      w_valid_q   <= w_valid_d;
      blocked_q   <= blocked_d;
    end
  end

  // FIFO storage; cleared on reset so stale words never reach the demux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {N{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

  assign f       = f_q;
  assign s       = s_q;
  assign w_valid = w_valid_q;
  assign count   = count_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_demux_lane_dispatcher.sv
// Scoreboard bench for demux_lane_dispatcher: a queue-based reference model
// predicts each dispatch, a negedge monitor compares what the DUT presents.
module tb_demux_lane_dispatcher;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      lane_ready;
  logic [N-1:0]    f;
  logic            s;
  logic [1:0]      w_valid;
  logic [CW-1:0]   count;
  logic            blocked;

  demux_lane_dispatcher #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lane_ready (lane_ready),
    .f          (f),
    .s          (s),
    .w_valid    (w_valid),
    .count      (count),
    .blocked    (blocked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         l;
    int           c;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [N-1:0] mq[$];
  exp_t         sb[$];
  logic         m_nl      = 1'b0;
  logic         m_blocked = 1'b0;
  int           m_sz;
  logic         m_lane;
  exp_t         m_e;
  exp_t         mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of words plus a "whose turn" bit.
  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      m_sz      = mq.size();
      m_blocked = (m_sz > 0) && (lane_ready == 2'b00);
      if (m_sz > 0 && lane_ready != 2'b00) begin
        m_lane = lane_ready[m_nl] ? m_nl : !m_nl;
        m_e.d  = mq.pop_front();
        m_e.l  = m_lane;
        m_e.c  = cyc;
        sb.push_back(m_e);
        m_nl   = !m_lane;
      end
      if (in_valid && m_sz < DEPTH) mq.push_back(in_data);
    end
  end

  always @(negedge reset_n) begin
    mq.delete();
    sb.delete();
    m_nl      = 1'b0;
    m_blocked = 1'b0;
  end

  // Monitor: compares occupancy every cycle and pops the scoreboard on each strobe.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("count", count, mq.size());
      chk("blocked", blocked, m_blocked);
      chk("in_ready", in_ready, mq.size() < DEPTH);
      while (sb.size() > 0 && sb[0].c < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_strobe: got no strobe expected word %0d on lane %0d at cycle %0d",
                 mon_e.d, mon_e.l, mon_e.c);
      end
      if (w_valid != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got w_valid=%b f=%0d expected no strobe (cycle %0d)",
                   w_valid, f, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("f", f, mon_e.d);
          chk("s", s, mon_e.l);
          chk("w_valid", w_valid, mon_e.l ? 2 : 1);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [N-1:0] d, input logic [1:0] lr);
    in_valid   = v;
    in_data    = d;
    lane_ready = lr;
    @(negedge clk);
    #1;
  endtask

  initial begin
    in_valid   = 1'b0;
    in_data    = '0;
    lane_ready = 2'b00;
    reset_n    = 1'b0;
    #12;
    chk("rst_f", f, 0);
    chk("rst_s", s, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_blocked", blocked, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    // Round-robin across both lanes
    drive(1'b1, 4'd3, 2'b11);
    drive(1'b1, 4'd5, 2'b11);
    drive(1'b1, 4'd7, 2'b11);
    drive(1'b1, 4'd9, 2'b11);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 2'b11);

    // Fill while both lanes stalled, then drain
    for (int i = 0; i < 6; i++) drive(1'b1, 4'(i + 1), 2'b00);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_blocked", blocked, 1);
    for (int i = 0; i < 6; i++) drive(1'b0, 4'd0, 2'b11);
    chk("drained_blocked", blocked, 0);
    chk("drained_count", count, 0);

    // Only lane 0 ready
    drive(1'b1, 4'd10, 2'b01);
    drive(1'b1, 4'd11, 2'b01);
    drive(1'b1, 4'd12, 2'b01);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 2'b01);

    // Half full with simultaneous push and pop, pointers wrap
    drive(1'b1, 4'd1, 2'b00);
    drive(1'b1, 4'd2, 2'b00);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 2'b11);
      chk("steady_count", count, 2);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 2'b11);

    // Asynchronous reset with words queued and a strobe live
    drive(1'b1, 4'd13, 2'b00);
    drive(1'b1, 4'd14, 2'b00);
    drive(1'b1, 4'd15, 2'b00);
    drive(1'b0, 4'd0, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_f", f, 0);
    chk("async_s", s, 0);
    chk("async_w_valid", w_valid, 0);
    chk("async_count", count, 0);
    chk("async_in_ready", in_ready, 1);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 4'd6, 2'b11);
    drive(1'b0, 4'd0, 2'b11);
    chk("post_rst_s", s, 0);
    chk("post_rst_w_valid", w_valid, 1);
    chk("post_rst_f", f, 6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < DEPTH + 3; i++) drive(1'b0, 4'd0, 2'b11);
    chk("final_scoreboard_empty", sb.size(), 0);
    chk("final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
